// File: rtl/sample_ramwriter.sv
// Periodic sample-RAM write engine: one full-width write every PERIOD clocks, pattern or captured data.
// First write lands INIT_DELAY+1 clocks after start; no backpressure, a capture slot with no sample is skipped.
module sample_ramwriter #(
  parameter int LANE_W     = 16,
  parameter int NUM_LANES  = 4,
  parameter int ADDR_W     = 14,
  parameter int START_ADDR = 1,
  parameter int PERIOD     = 500000,
  parameter int INIT_DELAY = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic                          i_capture,
  input  logic                          i_wrap,
  input  logic [LANE_W*NUM_LANES-1:0]   i_sample,
  input  logic                          i_sample_valid,
  output logic [LANE_W*NUM_LANES-1:0]   o_data,
  output logic [ADDR_W-1:0]             o_address,
  output logic [LANE_W*NUM_LANES/8-1:0] o_byteen,
  output logic                          o_wbit,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_overrun,
  output logic [ADDR_W:0]               o_count
);

  localparam int DW   = LANE_W * NUM_LANES;
  localparam int TMAX = (PERIOD > INIT_DELAY) ? PERIOD : INIT_DELAY + 1;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WRITE, S_WAIT, S_STOP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TW-1:0]     r_timer;
  logic              r_capture;
  logic              r_wrap;
  logic              r_pend;
  logic [DW-1:0]     r_hold;
  logic [LANE_W-1:0] r_base;
  logic [DW-1:0]     w_pattern;
  logic              w_slot;
  logic              w_ready;
  logic              w_top;
  logic              w_go_write;
  logic              w_consume;
  logic              w_active;

  // The timer keeps running through WRITE so slots stay on a fixed PERIOD grid.
  assign w_slot     = ((r_state == S_INIT) && (r_timer == TW'(INIT_DELAY))) ||
                      ((r_state == S_WAIT) && (r_timer == TW'(PERIOD - 1)));
  assign w_ready    = !r_capture || r_pend;
  assign w_top      = &o_address;
  assign w_go_write = (w_next == S_WRITE);
  assign w_consume  = w_go_write && r_capture;
  assign w_active   = (r_state == S_INIT) || (r_state == S_WRITE) || (r_state == S_WAIT);
  assign o_byteen   = '1;

  always_comb begin
    w_pattern = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_pattern[k*LANE_W +: LANE_W] = r_base + LANE_W'(k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_next = S_INIT;
      end
      S_INIT, S_WAIT: begin
        if (!i_enable)   w_next = S_IDLE;
        else if (w_slot) w_next = w_ready ? S_WRITE : S_WAIT;
      end
      S_WRITE: begin
        if (!i_enable)            w_next = S_IDLE;
        else if (w_top && !r_wrap) w_next = S_STOP;
        else                       w_next = S_WAIT;
      end
      S_STOP: begin
        if (!i_enable) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_wbit = (r_state == S_WRITE);
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_STOP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer   <= '0;
      r_capture <= 1'b0;
      r_wrap    <= 1'b0;
      r_base    <= '0;
      o_data    <= '0;
      o_address <= ADDR_W'(START_ADDR);
      o_count   <= '0;
    end else begin
      if (r_state == S_IDLE)       r_timer <= '0;
      else if (r_state != S_STOP)  r_timer <= w_slot ? '0 : r_timer + TW'(1);

      if ((r_state == S_IDLE) && i_enable) begin
        r_capture <= i_capture;
        r_wrap    <= i_wrap;
        r_base    <= '0;
        o_address <= ADDR_W'(START_ADDR);
        o_count   <= '0;
      end

      if (w_go_write) begin
        o_data <= r_capture ? r_hold : w_pattern;
        if (!r_capture) r_base <= r_base + LANE_W'(NUM_LANES);
      end

      // A one-shot fill parks on the top address rather than rolling to zero.
      if (r_state == S_WRITE) begin
        if (~&o_count) o_count <= o_count + (ADDR_W+1)'(1);
        if (!w_top)      o_address <= o_address + ADDR_W'(1);
        else if (r_wrap) o_address <= ADDR_W'(START_ADDR);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold    <= '0;
      r_pend    <= 1'b0;
      o_overrun <= 1'b0;
    end else if ((r_state == S_IDLE) && i_enable) begin
      r_pend    <= 1'b0;
      o_overrun <= 1'b0;
    end else if (w_active && i_sample_valid) begin
      r_hold <= i_sample;
      r_pend <= 1'b1;
      if (r_pend && !w_consume) o_overrun <= 1'b1;
    end else if (w_consume) begin
      r_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_ramwriter.sv
// Randomised bench for sample_ramwriter: slot-grid reference model plus directed literal checks.
module tb_sample_ramwriter;

  localparam int LW  = 16;
  localparam int NL  = 4;
  localparam int AW  = 4;
  localparam int SA  = 1;
  localparam int PER = 8;
  localparam int ID  = 2;
  localparam int DW  = LW * NL;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          cap   = 1'b0;
  logic          wrp   = 1'b0;
  logic          svld  = 1'b0;
  logic [DW-1:0] sdat  = '0;

  logic [DW-1:0]   o_data;
  logic [AW-1:0]   o_address;
  logic [DW/8-1:0] o_byteen;
  logic            o_wbit, o_busy, o_done, o_overrun;
  logic [AW:0]     o_count;

  int n_tests = 0;
  int n_fail  = 0;

  sample_ramwriter #(
    .LANE_W(LW), .NUM_LANES(NL), .ADDR_W(AW), .START_ADDR(SA), .PERIOD(PER), .INIT_DELAY(ID)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_capture(cap), .i_wrap(wrp),
    .i_sample(sdat), .i_sample_valid(svld),
    .o_data(o_data), .o_address(o_address), .o_byteen(o_byteen), .o_wbit(o_wbit),
    .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: run/idle/stop plus a write grid anchored at the start edge.
  int            m_mode;  // 0 idle, 1 running, 2 stopped
  int            m_t;
  int            m_addr;
  int            m_cnt;
  logic          m_cap, m_wrp, m_pend, m_wbit, m_ovr;
  logic [LW-1:0] m_base;
  logic [DW-1:0] m_data, m_hold;

  function automatic logic [DW-1:0] pat(input logic [LW-1:0] b);
    logic [DW-1:0] r;
    for (int k = 0; k < NL; k++) r[k*LW +: LW] = b + LW'(k);
    return r;
  endfunction

  function automatic bit is_slot(input int t);
    return (t >= ID + 1) && (((t - ID - 1) % PER) == 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_addr = SA; m_cnt = 0;
    m_cap = 0; m_wrp = 0; m_pend = 0; m_wbit = 0; m_ovr = 0;
    m_base = '0; m_data = '0; m_hold = '0;
  endtask

  task automatic model_step();
    bit consume;
    consume = 0;
    if (m_mode == 0) begin
      if (en) begin
        m_mode = 1; m_t = 0; m_base = '0; m_addr = SA; m_cnt = 0;
        m_ovr = 0; m_pend = 0; m_cap = cap; m_wrp = wrp;
      end
    end else if (m_mode == 2) begin
      if (!en) m_mode = 0;
    end else begin
      if (m_wbit) begin
        m_wbit = 0;
        if (m_cnt < 2**(AW+1) - 1) m_cnt++;
        if (m_addr == 2**AW - 1) begin
          if (m_wrp)   m_addr = SA;
          else if (en) m_mode = 2;
        end else begin
          m_addr++;
        end
      end
      if (!en) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        m_t++;
        if (is_slot(m_t) && (!m_cap || m_pend)) begin
          m_wbit = 1;
          if (m_cap) begin
            m_data = m_hold;
            consume = 1;
          end else begin
            m_data = pat(m_base);
            m_base = m_base + LW'(NL);
          end
        end
      end
      if (svld) begin
        if (m_pend && !consume) m_ovr = 1;
        m_hold = sdat;
        m_pend = 1;
      end else if (consume) begin
        m_pend = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("wbit",    64'(o_wbit),    64'(m_wbit));
      chk("busy",    64'(o_busy),    64'(m_mode != 0));
      chk("done",    64'(o_done),    64'(m_mode == 2));
      chk("address", 64'(o_address), 64'(m_addr));
      chk("count",   64'(o_count),   64'(m_cnt));
      chk("overrun", 64'(o_overrun), 64'(m_ovr));
      chk("data",    64'(o_data),    64'(m_data));
      chk("byteen",  64'(o_byteen),  64'hFF);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wbit(input string nm, input int max, output int waited);
    waited = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (o_wbit) begin
        waited = i;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: no write strobe within %0d cycles", nm, max);
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (o_wbit) pulses++;
    end
  endtask

  initial begin
    int w;
    int p;

    cyc(3);
    chk("rst_address", 64'(o_address), 64'd1);
    chk("rst_wbit",    64'(o_wbit),    64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    cyc(2);

    // Pattern, one-shot
    cap = 0; wrp = 0; en = 1;
    cyc(3);
    chk("first_early", 64'(o_wbit), 64'd0);
    cyc(1);
    chk("first_wbit", 64'(o_wbit),    64'd1);
    chk("first_data", o_data,         64'h0003_0002_0001_0000);
    chk("first_addr", 64'(o_address), 64'd1);
    wait_wbit("second", 20, w);
    chk("spacing",     64'(w),         64'd8);
    chk("second_data", o_data,         64'h0007_0006_0005_0004);
    chk("second_addr", 64'(o_address), 64'd2);
    for (int i = 3; i <= 15; i++) wait_wbit("oneshot", 20, w);
    chk("last_addr", 64'(o_address), 64'd15);
    cyc(3);
    chk("oneshot_done",  64'(o_done),  64'd1);
    chk("oneshot_count", 64'(o_count), 64'd15);
    en = 0;
    cyc(2);
    chk("stop_idle", 64'(o_busy), 64'd0);

    // Pattern, wrap, then drop enable during WAIT
    wrp = 1; en = 1;
    for (int i = 1; i <= 36; i++) begin
      wait_wbit("wrap", 20, w);
      if (i == 16) begin
        chk("wrap_addr", 64'(o_address), 64'd1);
        chk("wrap_data", o_data,         64'h003F_003E_003D_003C);
        chk("wrap_done", 64'(o_done),    64'd0);
      end
      if (i == 31) chk("count_30", 64'(o_count), 64'd30);
      if (i == 32) chk("count_31", 64'(o_count), 64'd31);
      if (i == 36) chk("count_sat", 64'(o_count), 64'd31);
    end
    cyc(3);
    en = 0;
    cyc(1);
    chk("wait_drop_busy", 64'(o_busy),    64'd0);
    chk("wait_drop_addr", 64'(o_address), 64'd7);
    count_pulses(20, p);
    chk("idle_no_pulse", 64'(p), 64'd0);

    // Re-enable, then drop enable on the WRITE cycle
    en = 1;
    wait_wbit("restart", 20, w);
    chk("restart_addr", 64'(o_address), 64'd1);
    chk("restart_data", o_data,         64'h0003_0002_0001_0000);
    wait_wbit("wr_drop", 20, w);
    en = 0;
    cyc(1);
    chk("wr_drop_wbit",  64'(o_wbit),    64'd0);
    chk("wr_drop_busy",  64'(o_busy),    64'd0);
    chk("wr_drop_addr",  64'(o_address), 64'd3);
    chk("wr_drop_count", 64'(o_count),   64'd2);
    count_pulses(12, p);
    chk("wr_drop_quiet", 64'(p), 64'd0);

    // Capture mode
    cap = 1; wrp = 1; en = 1;
    cyc(1);
    svld = 1; sdat = 64'hAAAA_AAAA_AAAA_AAAA;
    cyc(1);
    svld = 0;
    wait_wbit("cap_a", 20, w);
    chk("cap_a_data", o_data,         64'hAAAA_AAAA_AAAA_AAAA);
    chk("cap_a_addr", 64'(o_address), 64'd1);
    svld = 1; sdat = 64'h5555_5555_5555_5555;
    cyc(1);
    svld = 0;
    wait_wbit("cap_5", 20, w);
    chk("cap_5_data", o_data,         64'h5555_5555_5555_5555);
    chk("cap_5_addr", 64'(o_address), 64'd2);
    count_pulses(12, p);
    chk("cap_skip_pulse", 64'(p),         64'd0);
    chk("cap_skip_addr",  64'(o_address), 64'd3);
    svld = 1; sdat = 64'h1111_1111_1111_1111;
    cyc(1);
    sdat = 64'h2222_2222_2222_2222;
    cyc(1);
    svld = 0;
    wait_wbit("cap_ovr", 20, w);
    chk("ovr_data", o_data,         64'h2222_2222_2222_2222);
    chk("ovr_flag", 64'(o_overrun), 64'd1);
    chk("ovr_addr", 64'(o_address), 64'd3);
    for (int i = 0; i < 240; i++) begin
      svld = ($urandom_range(0, 5) == 0);
      sdat = {$urandom, $urandom};
      cyc(1);
    end
    svld = 0;
    chk("ovr_sticky", 64'(o_overrun), 64'd1);
    en = 0;
    cyc(2);
    en = 1;
    cyc(2);
    chk("ovr_cleared", 64'(o_overrun), 64'd0);
    chk("cap_restart_count", 64'(o_count), 64'd0);
    count_pulses(20, p);
    chk("cap_empty_pulse", 64'(p), 64'd0);
    en = 0;
    cyc(2);

    // Reset in the middle of a write pulse
    cap = 0; en = 1;
    wait_wbit("pre_reset", 20, w);
    wait_wbit("pre_reset2", 20, w);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wbit",  64'(o_wbit),    64'd0);
    chk("rst_mid_busy",  64'(o_busy),    64'd0);
    chk("rst_mid_data",  o_data,         64'd0);
    chk("rst_mid_addr",  64'(o_address), 64'd1);
    chk("rst_mid_count", 64'(o_count),   64'd0);
    chk("rst_mid_done",  64'(o_done),    64'd0);
    en = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_ramwriter.md
# sample_ramwriter

Parametrised successor to the periodic RAM write engine. Generates one full-width write to the on-chip sample RAM every PERIOD clocks. Each write carries NUM_LANES lanes of LANE_W bits, taken either from an internal counting test pattern or from a captured external sample. Sits between the acquisition front end and the RAM write port, with start/stop control, wrap/one-shot fill modes and overrun reporting.

## Interface
Parameters:
- LANE_W, 16, bits per lane; LANE_W*NUM_LANES must be a multiple of 8
- NUM_LANES, 4, lanes packed per RAM word; lane 0 in the LSBs
- ADDR_W, 14, RAM address width
- START_ADDR, 1, first address written after each start, and the wrap target
- PERIOD, 500000, clocks between write pulses; must be ≥ 3
- INIT_DELAY, 4, settle clocks between start and the first write

Ports (DW = LANE_W*NUM_LANES):
- i_clk  in  1  clock; all logic on the rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  level; high = run, low = stop and return to IDLE
- i_capture  in  1  0 = test pattern, 1 = external samples; sampled only in IDLE
- i_wrap  in  1  1 = wrap at the top address, 0 = one-shot; sampled only in IDLE
- i_sample  in  DW  external sample word
- i_sample_valid  in  1  single-cycle qualifier for i_sample
- o_data  out  DW  RAM write data, registered
- o_address  out  ADDR_W  RAM write address, registered
- o_byteen  out  DW/8  byte enables, constant all-ones
- o_wbit  out  1  one-cycle write strobe
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  high in STOP (one-shot fill complete)
- o_overrun  out  1  sticky; a pending capture sample was overwritten
- o_count  out  ADDR_W+1  writes since the last start, saturating at all-ones

## Operation
- Reset values: o_data=0, o_address=START_ADDR, o_wbit=0, o_busy=0, o_done=0, o_overrun=0, o_count=0, pattern base=0, state=IDLE, timer=0, no pending sample.
- IDLE:
  - If i_enable=1: latch mode and wrap, set o_address=START_ADDR, clear o_count, o_overrun, pattern base and pending flag, then go to INIT.
- INIT:
  - Count INIT_DELAY clocks, then go to WRITE.
- WRITE:
  - Occupies exactly one cycle with o_wbit=1.
  - o_data was loaded on the edge entering WRITE and holds until the next write.
  - Pattern mode: lane k = base+k mod 2^LANE_W; base advances by NUM_LANES per write.
  - Capture mode: o_data takes the pending sample; WRITE is entered only if a sample is pending.
- After WRITE:
  - o_address increments and o_count increments (saturating).
  - If the address just written was 2^ADDR_W−1: with wrap, o_address becomes START_ADDR; with one-shot, go to STOP.
  - Otherwise go to WAIT.
- WAIT:
  - Timer runs so that write pulses are spaced exactly PERIOD clocks apart.
  - On expiry in capture mode with nothing pending: no write, address unchanged, timer restarts.
- STOP:
  - Outputs hold. Go to IDLE when i_enable=0.
- i_enable low:
  - In INIT or WAIT: go to IDLE on the next edge.
  - In WRITE: the write completes, then go to IDLE.
  - o_data, o_address and o_count keep their values in IDLE.
- Capture path:
  - i_sample_valid loads a holding register and sets pending.
  - Valid on the same edge the pending sample transfers to o_data: the new sample becomes pending; no overrun.
  - Valid while a sample is pending and not being consumed: overwrite it and set o_overrun.
  - Samples are ignored in IDLE and STOP.

## Timing
- If i_enable is first sampled high at edge 0, the first o_wbit is high from edge INIT_DELAY+1 to edge INIT_DELAY+2.
- Subsequent write pulses are exactly PERIOD clocks apart in pattern mode.
- In capture mode, write pulses fall on multiples of PERIOD from the first write, skipping slots with no pending sample.
- o_address and o_data are stable for the whole o_wbit cycle; o_address changes on the edge that ends o_wbit.
- o_done rises on the edge ending the last one-shot write.
- Asynchronous reset at any point drops o_wbit immediately and restores all reset values; no partial write is retried.

## Test plan
- Setup for all cases: LANE_W=16, NUM_LANES=4, ADDR_W=4, START_ADDR=1, PERIOD=8, INIT_DELAY=2.
- Pattern, one-shot, enable held high:
  - 15 pulses 8 clocks apart at addresses 1..15.
  - Data 0x0003_0002_0001_0000, then 0x0007_0006_0005_0004, …
  - o_done=1 after address 15; o_count=15.
- Pattern, wrap: after address 15 the next write goes to address 1 with base 60 (lane0=0x003C), o_done stays 0, and o_count keeps counting to 31 and saturates there.
- Capture: one valid per period with 0xAAAA…, then 0x5555… → written in order; skip a period's valid → no pulse in that slot and the address is not advanced.
- Capture overrun: two valids within one period → the second value is written and o_overrun=1, held until the next start.
- i_enable dropped during WAIT and again on the WRITE cycle:
  - WAIT: no further pulse.
  - WRITE: that write completes.
  - Both cases: IDLE next, o_busy=0, o_address retained; re-enable restarts at address 1.
- Reset asserted mid-pulse: o_wbit falls immediately and all outputs return to their reset values.
